muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit in the execute stage, between the register file read ports and the write-back mux. Takes `RD1`/`RD2` operands plus the destination register index and `funct3`, computes the RV32M result over several cycles, then presents it with a one-cycle write-enable pulse that drives `WD3`/`AD3`/`WE3` through the write-back mux. The pipeline stalls on `busy`.

---
 rtl/muldiv_pkg.sv | 47 ++++
 rtl/muldiv_iter_core.sv | 78 +++++++
 rtl/muldiv_unit.sv | 178 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 codes, FSM states,
// special-case constants and funct3 decode helpers.
package muldiv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } muldiv_state_t;

    localparam logic [XLEN-1:0] DIV0_QUOT = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic f3_is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    function automatic logic f3_is_rem(input logic [2:0] f3);
        return f3[2] & f3[1];
    endfunction

    function automatic logic f3_a_signed(input logic [2:0] f3);
        case (f3)
            F3_MULH, F3_MULHSU, F3_DIV, F3_REM: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic logic f3_b_signed(input logic [2:0] f3);
        case (f3)
            F3_MULH, F3_DIV, F3_REM: return 1'b1;
            default:                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Shared radix-2 datapath: shift-add multiply or restoring divide on unsigned magnitudes,
// one bit per step, with the iteration counter. Product = {hi,lo}; quotient = lo, remainder = hi.
module muldiv_iter_core
    import muldiv_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] mag_a,
    input  logic [WIDTH-1:0] mag_b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             last
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] hi_r, lo_r, b_r;
    logic [CW-1:0]    count_r;
    logic             div_r;
    logic [WIDTH:0]   sum_s, shifted_s, diff_s;
    logic [WIDTH-1:0] hi_next_s, lo_next_s;

    // Next value of the hi/lo pair for one multiply or divide step
    always_comb begin
        sum_s     = {1'b0, hi_r} + (lo_r[0] ? {1'b0, b_r} : {(WIDTH+1){1'b0}});
        shifted_s = {hi_r, lo_r[WIDTH-1]};
        diff_s    = shifted_s - {1'b0, b_r};
        hi_next_s = hi_r;
        lo_next_s = lo_r;
        if (div_r) begin
            if (diff_s[WIDTH]) begin
                hi_next_s = shifted_s[WIDTH-1:0];
                lo_next_s = {lo_r[WIDTH-2:0], 1'b0};
            end else begin
                hi_next_s = diff_s[WIDTH-1:0];
                lo_next_s = {lo_r[WIDTH-2:0], 1'b1};
            end
        end else begin
            hi_next_s = sum_s[WIDTH:1];
            lo_next_s = {sum_s[0], lo_r[WIDTH-1:1]};
        end
    end

    // Datapath and iteration counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_r    <= {WIDTH{1'b0}};
            lo_r    <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            div_r   <= 1'b0;
            count_r <= {CW{1'b0}};
        end else if (load) begin
            hi_r    <= {WIDTH{1'b0}};
            lo_r    <= mag_a;
            b_r     <= mag_b;
            div_r   <= is_div;
            count_r <= {CW{1'b0}};
        end else if (step) begin
            hi_r    <= hi_next_s;
            lo_r    <= lo_next_s;
            count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            hi_r    <= hi_r;
            lo_r    <= lo_r;
            count_r <= count_r;
        end
    end

    assign hi   = hi_r;
    assign lo   = lo_r;
    assign last = (count_r == CW'(WIDTH - 1));

endmodule

// File: rtl/muldiv_unit.sv
// RV32M iterative multiply/divide unit: FSM, sign fix-up, special-case decode, output registers.
// Optional MULDIV_FAST_MUL_EN selects a single-cycle array multiply for MUL*.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [4:0]       rd_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       rd_out,
    output logic             we_out
);

    muldiv_state_t    state_r, state_next_s;
    logic [2:0]       f3_r;
    logic [4:0]       rd_r, rd_out_r;
    logic             neg_r, special_r, busy_r, done_r, we_r;
    logic [WIDTH-1:0] spec_val_r, result_r;

    logic             accept_s, sign_a_s, sign_b_s, neg_s, special_s, core_last_s;
    logic [WIDTH-1:0] mag_a_s, mag_b_s, special_val_s, core_hi_s, core_lo_s, quot_rem_s, final_s;
    logic [2*WIDTH-1:0] prod_s;
`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_prod_s;
`endif

    // busy stays high through the done cycle, so a new start is first taken in true idle
    assign accept_s = (state_r == IDLE) && !busy_r && start;

    // Operand magnitudes, result sign and special-case resolution at acceptance
    always_comb begin
        sign_a_s      = f3_a_signed(funct3) & op_a[WIDTH-1];
        sign_b_s      = f3_b_signed(funct3) & op_b[WIDTH-1];
        mag_a_s       = sign_a_s ? ({WIDTH{1'b0}} - op_a) : op_a;
        mag_b_s       = sign_b_s ? ({WIDTH{1'b0}} - op_b) : op_b;
        neg_s         = f3_is_rem(funct3) ? sign_a_s : (sign_a_s ^ sign_b_s);
        special_s     = 1'b0;
        special_val_s = {WIDTH{1'b0}};
`ifdef MULDIV_FAST_MUL_EN
        fast_prod_s   = {(2*WIDTH){1'b0}};
`endif
        if (f3_is_div(funct3)) begin
            if (op_b == {WIDTH{1'b0}}) begin
                special_s     = 1'b1;
                special_val_s = f3_is_rem(funct3) ? op_a : DIV0_QUOT;
            end else if (!funct3[0] && (op_a == INT_MIN) && (op_b == DIV0_QUOT)) begin
                special_s     = 1'b1;
                special_val_s = f3_is_rem(funct3) ? {WIDTH{1'b0}} : INT_MIN;
            end else begin
                special_s     = 1'b0;
            end
        end else begin
`ifdef MULDIV_FAST_MUL_EN
            special_s   = 1'b1;
            fast_prod_s = {{WIDTH{1'b0}}, mag_a_s} * {{WIDTH{1'b0}}, mag_b_s};
            if (neg_s) begin
                fast_prod_s = {(2*WIDTH){1'b0}} - fast_prod_s;
            end else begin
                fast_prod_s = fast_prod_s;
            end
            special_val_s = (funct3 == F3_MUL) ? fast_prod_s[WIDTH-1:0]
                                               : fast_prod_s[2*WIDTH-1:WIDTH];
`else
            special_s = 1'b0;
`endif
        end
    end

    muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .rst    (rst),
        .load   (accept_s && !special_s),
        .step   (state_r == CALC),
        .is_div (f3_is_div(funct3)),
        .mag_a  (mag_a_s),
        .mag_b  (mag_b_s),
        .hi     (core_hi_s),
        .lo     (core_lo_s),
        .last   (core_last_s)
    );

    // Sign fix-up and half/quotient/remainder selection of the finished operation
    always_comb begin
        prod_s     = {core_hi_s, core_lo_s};
        quot_rem_s = f3_is_rem(f3_r) ? core_hi_s : core_lo_s;
        if (neg_r) begin
            prod_s     = {(2*WIDTH){1'b0}} - prod_s;
            quot_rem_s = {WIDTH{1'b0}} - quot_rem_s;
        end else begin
            prod_s     = prod_s;
        end
        if (special_r) begin
            final_s = spec_val_r;
        end else if (f3_is_div(f3_r)) begin
            final_s = quot_rem_s;
        end else begin
            final_s = (f3_r == F3_MUL) ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH];
        end
    end

    // FSM next state
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = special_s ? DONE : CALC;
                end else begin
                    state_next_s = IDLE;
                end
            end
            CALC: begin
                if (core_last_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = CALC;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State, latched request fields and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            f3_r       <= 3'b000;
            rd_r       <= 5'd0;
            neg_r      <= 1'b0;
            special_r  <= 1'b0;
            spec_val_r <= {WIDTH{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            we_r       <= 1'b0;
            result_r   <= {WIDTH{1'b0}};
            rd_out_r   <= 5'd0;
        end else begin
            state_r <= state_next_s;
            if (accept_s) begin
                f3_r       <= funct3;
                rd_r       <= rd_in;
                neg_r      <= neg_s;
                special_r  <= special_s;
                spec_val_r <= special_val_s;
                busy_r     <= 1'b1;
            end else if (done_r) begin
                busy_r     <= 1'b0;
            end else begin
                busy_r     <= busy_r;
            end
            if (state_r == DONE) begin
                result_r <= final_s;
                rd_out_r <= rd_r;
                done_r   <= 1'b1;
                we_r     <= (rd_r != 5'd0);
            end else begin
                done_r   <= 1'b0;
                we_r     <= 1'b0;
            end
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign we_out = we_r;
    assign result = result_r;
    assign rd_out = rd_out_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases, busy/ignore/reset behaviour,
// and randomized operations against a 64-bit arithmetic reference model.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic [4:0]  rd_in = 5'd0;
    logic        busy, done, we_out;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .rd_in  (rd_in),
        .busy   (busy),
        .done   (done),
        .result (result),
        .rd_out (rd_out),
        .we_out (we_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [63:0] sa, sb, ub, p;
        logic [63:0] up;
        logic ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ub  = {32'd0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            F3_MUL:    begin up = {32'd0, a} * {32'd0, b}; return up[31:0]; end
            F3_MULH:   begin p = sa * sb; return p[63:32]; end
            F3_MULHSU: begin p = sa * ub; return p[63:32]; end
            F3_MULHU:  begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
            F3_DIV:    begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                else if (ovf) return a;
                else begin p = sa / sb; return p[31:0]; end
            end
            F3_DIVU:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            F3_REM:    begin
                if (b == 32'd0) return a;
                else if (ovf) return 32'd0;
                else begin p = sa % sb; return p[31:0]; end
            end
            default:   return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_latency(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b);
        if (f3[2]) begin
            if ((b == 32'd0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
            else return 33;
        end
`ifdef MULDIV_FAST_MUL_EN
        return 1;
`else
        return 33;
`endif
    endfunction

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp, input bit ghost);
        int n;
        int base;
        for (int i = 0; i < 50 && busy; i++) @(posedge clk);
        @(negedge clk);
        funct3 = f3; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        base = done_cnt;
        n = 0;
        while (n < 100) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) check_val("busy_after_accept", 32'(busy), 32'd1);
            if (ghost && n == 4) begin
                start = 1'b1; op_a = ~a; funct3 = F3_MULHU; rd_in = ~rd;
            end else begin
                start = 1'b0;
            end
            if (done) break;
        end
        start = 1'b0;
        check_val("done_seen", 32'(done), 32'd1);
        check_val("latency", n, exp_latency(f3, a, b));
        check_val("result", result, exp);
        check_val("rd_out", 32'(rd_out), 32'(rd));
        check_val("we_out", 32'(we_out), 32'(rd != 5'd0));
        @(posedge clk); #1;
        check_val("done_pulse_end", 32'(done), 32'd0);
        check_val("busy_end", 32'(busy), 32'd0);
        check_val("result_hold", result, exp);
        check_val("done_count", done_cnt - base, 1);
        if (ghost) begin
            repeat (40) @(posedge clk);
            #1;
            check_val("ghost_ignored", done_cnt - base, 1);
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [2:0]  f3;
        logic [31:0] a, b;
        logic [4:0]  rd;
        int n;

        #2 rst = 1'b0;
        #2;
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_we", 32'(we_out), 32'd0);
        check_val("rst_result", result, 32'd0);
        check_val("rst_rd_out", 32'(rd_out), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;

        run_op(F3_MUL,    32'd7,          32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 1'b0);
        run_op(F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd1, 32'hFFFF_FFFE, 1'b0);
        run_op(F3_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2, 32'h0000_0000, 1'b0);
        run_op(F3_MULHSU, 32'hFFFF_FFFF,  32'd2,         5'd3, 32'hFFFF_FFFF, 1'b0);
        run_op(F3_DIV,    32'hFFFF_FFF9,  32'd2,         5'd4, 32'hFFFF_FFFD, 1'b0);
        run_op(F3_REM,    32'hFFFF_FFF9,  32'd2,         5'd6, 32'hFFFF_FFFF, 1'b0);
        run_op(F3_DIVU,   32'd100,        32'd7,         5'd7, 32'd14,        1'b0);
        run_op(F3_REMU,   32'd100,        32'd7,         5'd8, 32'd2,         1'b0);
        run_op(F3_DIV,    32'd5,          32'd0,         5'd9, 32'hFFFF_FFFF, 1'b0);
        run_op(F3_REM,    32'd5,          32'd0,        5'd10, 32'd5,         1'b0);
        run_op(F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1'b0);
        run_op(F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 32'd0,        1'b0);
        run_op(F3_DIVU,   32'd1000,       32'd9,        5'd13, 32'd111,       1'b1);
        run_op(F3_REMU,   32'd1000,       32'd9,         5'd0, 32'd1,         1'b0);

        // Reset during CALC
        @(negedge clk);
        funct3 = F3_DIVU; op_a = 32'd12345; op_b = 32'd7; rd_in = 5'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check_val("midrst_busy", 32'(busy), 32'd0);
        check_val("midrst_done", 32'(done), 32'd0);
        check_val("midrst_we", 32'(we_out), 32'd0);
        check_val("midrst_result", result, 32'd0);
        n = done_cnt;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check_val("midrst_no_done", done_cnt - n, 0);
        run_op(F3_DIVU, 32'd9, 32'd3, 5'd14, 32'd3, 1'b0);

        for (int i = 0; i < 150; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = pick_operand();
            b  = pick_operand();
            rd = 5'($urandom_range(0, 31));
            run_op(f3, a, b, rd, ref_model(f3, a, b), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
